// File: rtl/shift_sequencer_if.sv
// Request/response bundle between the EX-stage control unit and the shift sequencer.
interface shift_sequencer_if;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  sh_amt;
  logic [31:0] operand;
  logic [31:0] result;
  logic        busy;
  logic        done;

  modport master (
    output start, op, sh_amt, operand,
    input  result, busy, done
  );

  modport slave (
    input  start, op, sh_amt, operand,
    output result, busy, done
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA/ROTR unit: shifts at most STEP bit positions per clock
// instead of using a full 32-bit barrel shifter.
module shift_sequencer #(
  parameter int unsigned STEP = 1
) (
  input logic               clk,
  input logic               reset,
  shift_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [4:0] StepAmt = 5'(STEP);

  state_e      state_q, state_d;
  logic [31:0] d_q, d_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  opr_q, opr_d;
  logic        busy_q, done_q;
  logic [4:0]  n;
  logic [31:0] shifted;

  // Amount shifted this cycle; never zero while in StShift since cnt_q > 0 there.
  always_comb begin
    n = (cnt_q < StepAmt) ? cnt_q : StepAmt;
  end

  always_comb begin
    shifted = d_q;
    unique case (opr_q)
      2'b00: shifted = d_q << n;
      2'b01: shifted = d_q >> n;
      2'b10: shifted = $signed(d_q) >>> n;
      2'b11: shifted = (d_q >> n) | (d_q << (6'd32 - {1'b0, n}));
      default: shifted = d_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    opr_d   = opr_q;
    unique case (state_q)
      // DONE accepts a new request exactly like IDLE, so back-to-back ops have no bubble.
      StIdle, StDone: begin
        if (bus.start) begin
          d_d     = bus.operand;
          cnt_d   = bus.sh_amt;
          opr_d   = bus.op;
          state_d = (bus.sh_amt == 5'd0) ? StDone : StShift;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        d_d     = shifted;
        cnt_d   = cnt_q - n;
        state_d = (cnt_q == n) ? StDone : StShift;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      d_q     <= 32'd0;
      cnt_q   <= 5'd0;
      opr_q   <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      opr_q   <= opr_d;
      busy_q  <= (state_d == StShift);
      done_q  <= (state_d == StDone);
    end
  end

  assign bus.result = d_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench: two sequencers (STEP=1 and STEP=4) driven with directed and random
// requests; a negedge monitor checks Busy/Done timing and Result against a reference model.
module tb_shift_sequencer;

  typedef struct {
    logic [31:0] res;
    int          acc;
    int          dc;
  } exp_t;

  logic clk = 1'b0;
  logic rst0, rst1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic finish_req = 1'b0;

  exp_t        exp_q[2][$];
  int          next_free[2];
  logic        rst_pend[2];
  logic        mon_en[2];
  logic [31:0] last_res[2];

  shift_sequencer_if bus0 ();
  shift_sequencer_if bus1 ();

  shift_sequencer #(.STEP(1)) u_dut0 (.clk(clk), .reset(rst0), .bus(bus0));
  shift_sequencer #(.STEP(4)) u_dut1 (.clk(clk), .reset(rst1), .bus(bus1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain shift semantics; rotate via a doubled word.
  function automatic logic [31:0] ref_shift(input logic [1:0] op, input int sh,
                                            input logic [31:0] v);
    logic [63:0] dbl;
    case (op)
      2'd0: return v << sh;
      2'd1: return v >> sh;
      2'd2: return $signed(v) >>> sh;
      default: begin
        dbl = {v, v} >> sh;
        return dbl[31:0];
      end
    endcase
  endfunction

  task automatic drive(input int k, input logic s, input logic [1:0] op,
                       input logic [4:0] sh, input logic [31:0] v);
    if (k == 0) begin
      bus0.start = s; bus0.op = op; bus0.sh_amt = sh; bus0.operand = v;
    end else begin
      bus1.start = s; bus1.op = op; bus1.sh_amt = sh; bus1.operand = v;
    end
  endtask

  task automatic issue(input int k, input logic [1:0] op, input logic [4:0] sh,
                       input logic [31:0] v);
    exp_t e;
    int   step;
    int   l;
    while (cyc < next_free[k]) begin
      @(posedge clk); #1;
    end
    drive(k, 1'b1, op, sh, v);
    step  = (k == 0) ? 1 : 4;
    l     = 1 + (int'(sh) + step - 1) / step;
    e.res = ref_shift(op, int'(sh), v);
    e.acc = cyc + 1;
    e.dc  = cyc + l;
    exp_q[k].push_back(e);
    next_free[k] = e.dc;
    @(posedge clk); #1;
    drive(k, 1'b0, 2'($urandom), 5'($urandom), $urandom);
  endtask

  // A start while shifting must be ignored.
  task automatic spurious(input int k);
    if (cyc < next_free[k]) begin
      drive(k, 1'b1, 2'($urandom), 5'($urandom), 32'hFFFF_FFFF);
      @(posedge clk); #1;
      drive(k, 1'b0, 2'($urandom), 5'($urandom), $urandom);
    end
  endtask

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", name, k, cyc, act, want);
    end
  endtask

  always @(negedge clk) begin
    logic        exp_busy, exp_done, b, d, r;
    logic [31:0] res_v;
    for (int k = 0; k < 2; k++) begin
      b     = (k == 0) ? bus0.busy : bus1.busy;
      d     = (k == 0) ? bus0.done : bus1.done;
      res_v = (k == 0) ? bus0.result : bus1.result;
      r     = (k == 0) ? rst0 : rst1;
      if (rst_pend[k]) begin
        exp_q[k].delete();
        last_res[k] = 32'd0;
        mon_en[k]   = 1'b1;
      end
      rst_pend[k] = r;
      if (mon_en[k]) begin
        exp_busy = 1'b0;
        exp_done = 1'b0;
        if (exp_q[k].size() > 0 && cyc >= exp_q[k][0].acc) begin
          exp_busy = cyc < exp_q[k][0].dc;
          exp_done = cyc == exp_q[k][0].dc;
        end
        chk("busy", k, {31'd0, b}, {31'd0, exp_busy});
        chk("done", k, {31'd0, d}, {31'd0, exp_done});
        if (exp_done) begin
          chk("result", k, res_v, exp_q[k][0].res);
          last_res[k] = exp_q[k][0].res;
          void'(exp_q[k].pop_front());
        end else if (!exp_busy) begin
          chk("hold", k, res_v, last_res[k]);
        end
      end
    end
    if (finish_req || cyc > 50000) begin
      if (!finish_req) begin
        total++;
        bad++;
        $display("FAIL timeout cyc=%0d", cyc);
      end
      for (int k = 0; k < 2; k++) begin
        total++;
        if (exp_q[k].size() != 0) begin
          bad++;
          $display("FAIL drain dut%0d got=%0d want=0 pending", k, exp_q[k].size());
        end
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    rst_pend[0] = 1'b0; rst_pend[1] = 1'b0;
    mon_en[0]   = 1'b0; mon_en[1]   = 1'b0;
    last_res[0] = 32'd0; last_res[1] = 32'd0;
    next_free[0] = 0; next_free[1] = 0;
    rst0 = 1'b1;
    rst1 = 1'b1;
    drive(0, 1'b0, 2'd0, 5'd0, 32'd0);
    drive(1, 1'b0, 2'd0, 5'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst0 = 1'b0;
    rst1 = 1'b0;
    next_free[0] = cyc;
    next_free[1] = cyc;
    repeat (3) @(posedge clk);
    #1;

    // STEP=1 directed cases
    issue(0, 2'd0, 5'd31, 32'h0000_0001);
    issue(0, 2'd2, 5'd4,  32'h8000_00F0);
    issue(0, 2'd1, 5'd4,  32'h8000_00F0);
    issue(0, 2'd3, 5'd1,  32'h0000_0001);
    issue(0, 2'd2, 5'd0,  32'hDEAD_BEEF);
    issue(0, 2'd0, 5'd8,  32'h0000_0001);
    spurious(0);
    issue(0, 2'd1, 5'd8,  32'h0000_0100);

    // STEP=4 directed cases, second one cut by reset in its 2nd Busy cycle
    issue(1, 2'd2, 5'd10, 32'h8000_0000);
    issue(1, 2'd2, 5'd10, 32'h8000_0000);
    @(posedge clk); #1;
    rst1 = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b0;
    next_free[1] = cyc;
    repeat (3) @(posedge clk);
    #1;

    // Random traffic on each unit
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 40; i++) begin
        logic [4:0] sh;
        sh = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        issue(k, 2'($urandom), sh, $urandom);
        if ($urandom_range(0, 3) == 0) spurious(k);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end

    for (int i = 0; i < 200 && (exp_q[0].size() != 0 || exp_q[1].size() != 0); i++) begin
      @(posedge clk);
    end
    repeat (3) @(posedge clk);
    #1;
    finish_req = 1'b1;
  end

endmodule
